wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Write-back stage of the 5-stage LoongArch pipeline, directly downstream of the memory stage.
- Latches the 125-bit ME_to_WB bus and commits GPR writes.
- Drives CSR writes and raises exception/ertn flushes for the whole pipeline.
- Supplies forwarding data, the ID system-op interlock, debug trace and a 64-bit retired-instruction counter.

Parameters:
- ME_to_WB_Bus_Size, 125, width of the incoming stage bus.
- ECODE_W, 6, width of the exception code field.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ME_to_WB_Valid  in  1  ME stage has a valid instruction for WB.
- ME_to_WB_Bus  in  125  {excp_en[124], excp_num[123:118], csr_num[117:104], csr_we[103], csr_wvalue[102:71], inst_ertn[70], pc[69:38], gr_we[37], dest[36:32], result[31:0]}.
- WB_Allow_in  out  1  WB can accept from ME.
- rf_we  out  1  GPR write enable.
- rf_waddr  out  5  GPR write address.
- rf_wdata  out  32  GPR write data.
- WB_dest  out  5  dest for ID hazard check; 0 when no write.
- WB_Forward_Res  out  32  forwarding value.
- WB_to_ID_Sys_op  out  1  exception or ertn in WB.
- csr_we  out  1  CSR write enable.
- csr_num  out  14  CSR address.
- csr_wvalue  out  32  CSR write data.
- excp_flush  out  1  exception commit flush.
- ertn_flush  out  1  ertn commit flush.
- wb_ecode  out  6  exception code to CSR file.
- wb_pc  out  32  PC of the WB instruction, for ERA.
- instret  out  64  retired-instruction count.
- debug_wb_pc  out  32  trace PC.
- debug_wb_rf_we  out  4  trace write strobe.
- debug_wb_rf_wnum  out  5  trace register number.
- debug_wb_rf_wdata  out  32  trace write data.

Behaviour:
- **Reset.** While reset=0 (asynchronous), all of the following clear:
  - WB_Valid=0, all latched fields=0, instret=0, state=RUN.
  - As a result every output is 0 and WB_Allow_in=1.
- **Ready and allow-in.**
  - WB_ReadyGO=1 always.
  - WB_Allow_in = !WB_Valid || WB_ReadyGO, which is therefore constant 1 out of reset.
- **Latching.**
  - On posedge clk, when ME_to_WB_Valid && WB_Allow_in && state==RUN, load all bus fields.
  - WB_Valid <= ME_to_WB_Valid in RUN.
- **Commit.**
  - flush = WB_Valid & (excp_en | inst_ertn).
  - rf_we = WB_Valid & gr_we & ~flush.
  - csr_we = WB_Valid & csr_we_f & ~excp_en.
  - rf_waddr=dest, rf_wdata=result, csr_num/csr_wvalue pass through.
- **Flush outputs** (combinational, same cycle as the instruction sits in WB):
  - excp_flush = WB_Valid & excp_en.
  - ertn_flush = WB_Valid & inst_ertn & ~excp_en. Exception has priority.
  - wb_ecode = excp_num when excp_flush, else 0.
  - wb_pc = pc.
- **FSM (2 states).**
  - RUN: normal operation. If flush is asserted, go to KILL at the next edge, and force WB_Valid <= 0 regardless of ME_to_WB_Valid. The younger instruction presented in the flush cycle is discarded, never latched.
  - KILL: lasts exactly one cycle. WB_Valid stays 0 and incoming valid is ignored. Return to RUN unconditionally.
  - Consequence: each flush output is a single-cycle pulse.
- **Forwarding and interlock.**
  - WB_dest = dest & {5{WB_Valid & gr_we}}.
  - WB_Forward_Res = result & {32{gr_we}}.
  - WB_to_ID_Sys_op = flush.
- **instret.**
  - Increments by 1 on each clock where WB_Valid && !excp_en. An ertn counts as retired.
  - Unsigned 64-bit, wraps from 2^64-1 to 0.
- **Debug trace.**
  - debug_wb_pc = pc & {32{WB_Valid}}.
  - debug_wb_rf_we = {4{rf_we}}.
  - debug_wb_rf_wnum = dest.
  - debug_wb_rf_wdata = rf_wdata.
- **Simultaneous events.**
  - excp_en and csr_we in the same instruction: no CSR write, no GPR write.
  - excp_en and inst_ertn: only excp_flush.
  - gr_we with dest=0: rf_we still asserts; the regfile ignores r0.
  - Reset asserted mid-flush: the async clear wins and the FSM returns to RUN.

Test Plan:
- **Reset.** Hold reset=0 for 3 cycles with ME_to_WB_Valid=1 → all outputs 0, WB_Allow_in=1, instret=0. Release → first valid bus latched at the next edge.
- **Back-to-back ALU writes.** Three consecutive valid instructions, pc=0x1c000000/04/08, dest=5/6/7, result=0x11/0x22/0x33, gr_we=1 → rf_we=1 each cycle with matching waddr/wdata; debug_wb_rf_we=4'hf; instret=3.
- **Syscall exception.** excp_en=1, excp_num=0x0B, pc=0x1c000100, csr_we=1, gr_we=1 → excp_flush=1 for exactly 1 cycle, wb_ecode=0x0B, wb_pc=0x1c000100, rf_we=0, csr_we=0. A valid younger instruction at ME in the same cycle is not latched; the next commit is at least 2 cycles later. instret unchanged.
- **ertn.** inst_ertn=1, excp_en=0 → ertn_flush 1-cycle pulse, excp_flush=0, WB_to_ID_Sys_op=1, instret+1.
- **CSR write.** csr_we=1, csr_num=0x0006, csr_wvalue=0xDEADBEEF, gr_we=1, result=0x5 → csr_we=1 with those values; rf_wdata=0x5.
- **Bubble and forwarding.** ME_to_WB_Valid=0 → WB_dest=0, rf_we=0, debug_wb_pc=0. With gr_we=0 and result=0x1234 → WB_Forward_Res=0.

Source files
------------

// File: rtl/wb_unit.sv
// Write-back stage: latches the ME->WB bus, commits GPR/CSR writes, raises
// exception/ertn flushes and keeps the retired-instruction counter.
module wb_unit #(
    parameter int ME_to_WB_Bus_Size = 125,
    parameter int ECODE_W           = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ME_to_WB_Valid,
    input  logic [ME_to_WB_Bus_Size-1:0] ME_to_WB_Bus,
    output logic                         WB_Allow_in,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [31:0]                  rf_wdata,
    output logic [4:0]                   WB_dest,
    output logic [31:0]                  WB_Forward_Res,
    output logic                         WB_to_ID_Sys_op,
    output logic                         csr_we,
    output logic [13:0]                  csr_num,
    output logic [31:0]                  csr_wvalue,
    output logic                         excp_flush,
    output logic                         ertn_flush,
    output logic [ECODE_W-1:0]           wb_ecode,
    output logic [31:0]                  wb_pc,
    output logic [63:0]                  instret,
    output logic [31:0]                  debug_wb_pc,
    output logic [3:0]                   debug_wb_rf_we,
    output logic [4:0]                   debug_wb_rf_wnum,
    output logic [31:0]                  debug_wb_rf_wdata
);

    typedef enum logic {RUN = 1'b0, KILL = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic                wb_valid_reg, wb_valid_next;
    logic                load;
    logic                wb_ready_go;
    logic                flush;

    logic                excp_en_reg;
    logic [ECODE_W-1:0]  excp_num_reg;
    logic [13:0]         csr_num_reg;
    logic                csr_we_reg;
    logic [31:0]         csr_wvalue_reg;
    logic                inst_ertn_reg;
    logic [31:0]         pc_reg;
    logic                gr_we_reg;
    logic [4:0]          dest_reg;
    logic [31:0]         result_reg;
    logic [63:0]         instret_reg;

    assign wb_ready_go = 1'b1;
    assign WB_Allow_in = !wb_valid_reg || wb_ready_go;
    assign flush       = wb_valid_reg & (excp_en_reg | inst_ertn_reg);

    // A committing flush spends one KILL cycle so the younger instruction
    // presented alongside it is dropped and the flush pulse stays one cycle.
    always_comb begin
        state_next    = state_reg;
        wb_valid_next = wb_valid_reg;
        load          = 1'b0;
        case (state_reg)
            RUN: begin
                if (flush) begin
                    state_next    = KILL;
                    wb_valid_next = 1'b0;
                end else begin
                    wb_valid_next = ME_to_WB_Valid;
                    load          = ME_to_WB_Valid && WB_Allow_in;
                end
            end
            KILL: begin
                state_next    = RUN;
                wb_valid_next = 1'b0;
            end
            default: begin
                state_next    = RUN;
                wb_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= RUN;
            wb_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wb_valid_reg <= wb_valid_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            excp_en_reg    <= 1'b0;
            excp_num_reg   <= '0;
            csr_num_reg    <= '0;
            csr_we_reg     <= 1'b0;
            csr_wvalue_reg <= '0;
            inst_ertn_reg  <= 1'b0;
            pc_reg         <= '0;
            gr_we_reg      <= 1'b0;
            dest_reg       <= '0;
            result_reg     <= '0;
        end else if (load) begin
            excp_en_reg    <= ME_to_WB_Bus[124];
            excp_num_reg   <= ME_to_WB_Bus[123:118];
            csr_num_reg    <= ME_to_WB_Bus[117:104];
            csr_we_reg     <= ME_to_WB_Bus[103];
            csr_wvalue_reg <= ME_to_WB_Bus[102:71];
            inst_ertn_reg  <= ME_to_WB_Bus[70];
            pc_reg         <= ME_to_WB_Bus[69:38];
            gr_we_reg      <= ME_to_WB_Bus[37];
            dest_reg       <= ME_to_WB_Bus[36:32];
            result_reg     <= ME_to_WB_Bus[31:0];
        end
    end

    // ertn retires; an excepting instruction does not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_reg <= '0;
        end else if (wb_valid_reg && !excp_en_reg) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign rf_we             = wb_valid_reg & gr_we_reg & ~flush;
    assign rf_waddr          = dest_reg;
    assign rf_wdata          = result_reg;
    assign csr_we            = wb_valid_reg & csr_we_reg & ~excp_en_reg;
    assign csr_num           = csr_num_reg;
    assign csr_wvalue        = csr_wvalue_reg;
    assign excp_flush        = wb_valid_reg & excp_en_reg;
    assign ertn_flush        = wb_valid_reg & inst_ertn_reg & ~excp_en_reg;
    assign wb_ecode          = excp_flush ? excp_num_reg : '0;
    assign wb_pc             = pc_reg;
    assign WB_dest           = dest_reg & {5{wb_valid_reg & gr_we_reg}};
    assign WB_Forward_Res    = result_reg & {32{gr_we_reg}};
    assign WB_to_ID_Sys_op   = flush;
    assign instret           = instret_reg;
    assign debug_wb_pc       = pc_reg & {32{wb_valid_reg}};
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_reg;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: instructions pushed to a scoreboard when driven,
// popped and checked when they sit in WB.
module tb_wb_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         ME_to_WB_Valid;
    logic [124:0] ME_to_WB_Bus;
    logic         WB_Allow_in, rf_we, WB_to_ID_Sys_op, csr_we, excp_flush, ertn_flush;
    logic [4:0]   rf_waddr, WB_dest, debug_wb_rf_wnum;
    logic [31:0]  rf_wdata, WB_Forward_Res, csr_wvalue, wb_pc, debug_wb_pc, debug_wb_rf_wdata;
    logic [13:0]  csr_num;
    logic [5:0]   wb_ecode;
    logic [63:0]  instret;
    logic [3:0]   debug_wb_rf_we;

    always #5 clk = ~clk;

    wb_unit dut (
        .clk(clk), .reset(reset), .ME_to_WB_Valid(ME_to_WB_Valid), .ME_to_WB_Bus(ME_to_WB_Bus),
        .WB_Allow_in(WB_Allow_in), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .WB_dest(WB_dest), .WB_Forward_Res(WB_Forward_Res), .WB_to_ID_Sys_op(WB_to_ID_Sys_op),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wvalue(csr_wvalue),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_pc(wb_pc),
        .instret(instret), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    typedef struct {
        logic        e;
        logic [5:0]  num;
        logic [13:0] cn;
        logic        cw;
        logic [31:0] cv;
        logic        r;
        logic [31:0] pc;
        logic        g;
        logic [4:0]  d;
        logic [31:0] res;
    } inst_t;

    inst_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference view of the stage, derived from the write-back rules.
    logic  m_valid = 1'b0, m_kill = 1'b0, m_excp = 1'b0, m_ertn = 1'b0;
    logic [63:0] exp_instret = 64'd0;

    function automatic inst_t mk(logic e, logic [5:0] num, logic [13:0] cn, logic cw,
                                 logic [31:0] cv, logic r, logic [31:0] pc, logic g,
                                 logic [4:0] d, logic [31:0] res);
        inst_t t;
        t.e = e; t.num = num; t.cn = cn; t.cw = cw; t.cv = cv;
        t.r = r; t.pc = pc; t.g = g; t.d = d; t.res = res;
        return t;
    endfunction

    function automatic logic [124:0] pack(inst_t t);
        return {t.e, t.num, t.cn, t.cw, t.cv, t.r, t.pc, t.g, t.d, t.res};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one bus value for one clock, advance the reference, then check.
    task automatic drive(string tag, logic v, inst_t t);
        inst_t x;
        logic  fl, rw;
        ME_to_WB_Valid = v;
        ME_to_WB_Bus   = pack(t);
        @(posedge clk);
        if (m_valid && !m_excp) exp_instret = exp_instret + 64'd1;
        if (m_kill) begin
            m_kill  = 1'b0;
            m_valid = 1'b0;
        end else if (m_valid && (m_excp || m_ertn)) begin
            m_kill  = 1'b1;
            m_valid = 1'b0;
        end else begin
            m_valid = v;
            if (v) begin
                q.push_back(t);
                m_excp = t.e;
                m_ertn = t.r;
            end
        end
        #1;
        if (m_valid && q.size() > 0) begin
            x  = q.pop_front();
            fl = x.e | x.r;
            rw = x.g & ~fl;
            check({tag, ".rf_we"},      rf_we,            rw);
            check({tag, ".rf_waddr"},   rf_waddr,         x.d);
            check({tag, ".rf_wdata"},   rf_wdata,         x.res);
            check({tag, ".csr_we"},     csr_we,           x.cw & ~x.e);
            check({tag, ".csr_num"},    csr_num,          x.cn);
            check({tag, ".csr_wvalue"}, csr_wvalue,       x.cv);
            check({tag, ".excp_flush"}, excp_flush,       x.e);
            check({tag, ".ertn_flush"}, ertn_flush,       x.r & ~x.e);
            check({tag, ".wb_ecode"},   wb_ecode,         x.e ? x.num : 6'd0);
            check({tag, ".wb_pc"},      wb_pc,            x.pc);
            check({tag, ".WB_dest"},    WB_dest,          x.g ? x.d : 5'd0);
            check({tag, ".fwd"},        WB_Forward_Res,   x.g ? x.res : 32'd0);
            check({tag, ".sysop"},      WB_to_ID_Sys_op,  fl);
            check({tag, ".dbg_pc"},     debug_wb_pc,      x.pc);
            check({tag, ".dbg_we"},     debug_wb_rf_we,   {4{rw}});
            check({tag, ".dbg_wnum"},   debug_wb_rf_wnum, x.d);
            check({tag, ".dbg_wdata"},  debug_wb_rf_wdata, x.res);
        end else begin
            check({tag, ".idle_rf_we"},  rf_we,           1'b0);
            check({tag, ".idle_csr_we"}, csr_we,          1'b0);
            check({tag, ".idle_excp"},   excp_flush,      1'b0);
            check({tag, ".idle_ertn"},   ertn_flush,      1'b0);
            check({tag, ".idle_sysop"},  WB_to_ID_Sys_op, 1'b0);
            check({tag, ".idle_dest"},   WB_dest,         5'd0);
            check({tag, ".idle_dbg_pc"}, debug_wb_pc,     32'd0);
            check({tag, ".idle_ecode"},  wb_ecode,        6'd0);
        end
        check({tag, ".allow_in"}, WB_Allow_in, 1'b1);
        check({tag, ".instret"},  instret,     exp_instret);
        $display("step %-10s valid=%0b pc=%h rf_we=%0b excp=%0b ertn=%0b instret=%0d",
                 tag, v, t.pc, rf_we, excp_flush, ertn_flush, instret);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, ".allow_in"}, WB_Allow_in,     1'b1);
        check({tag, ".instret"},  instret,         64'd0);
        check({tag, ".rf_we"},    rf_we,           1'b0);
        check({tag, ".rf_wdata"}, rf_wdata,        32'd0);
        check({tag, ".csr_we"},   csr_we,          1'b0);
        check({tag, ".excp"},     excp_flush,      1'b0);
        check({tag, ".ertn"},     ertn_flush,      1'b0);
        check({tag, ".wb_pc"},    wb_pc,           32'd0);
        check({tag, ".dest"},     WB_dest,         5'd0);
        check({tag, ".dbg_pc"},   debug_wb_pc,     32'd0);
        check({tag, ".dbg_we"},   debug_wb_rf_we,  4'd0);
        $display("reset %s instret=%0d allow_in=%0b", tag, instret, WB_Allow_in);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_t nop, sys;
        nop = mk(0, 0, 0, 0, 0, 0, 32'h1c00_0ff0, 1, 5'd9, 32'h99);

        reset          = 1'b0;
        ME_to_WB_Valid = 1'b1;
        ME_to_WB_Bus   = pack(mk(1, 6'h3f, 14'h3fff, 1, 32'hffff_ffff, 1, 32'hffff_ffff, 1, 5'h1f, 32'hffff_ffff));
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b1;

        drive("alu0", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0000, 1, 5'd5, 32'h11));
        drive("alu1", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0004, 1, 5'd6, 32'h22));
        drive("alu2", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0008, 1, 5'd7, 32'h33));
        drive("bub0", 0, nop);
        check("alu.instret3", instret, 64'd3);

        sys = mk(1, 6'h0b, 14'h0001, 1, 32'h1234_5678, 0, 32'h1c00_0100, 1, 5'd4, 32'hab);
        drive("syscall", 1, sys);
        drive("young0", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0104, 1, 5'd8, 32'h44));
        drive("young1", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0108, 1, 5'd8, 32'h55));
        drive("after", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0200, 1, 5'd10, 32'h66));
        check("sys.instret", instret, 64'd3);

        drive("ertn", 1, mk(0, 0, 0, 0, 0, 1, 32'h1c00_0300, 0, 5'd0, 32'h0));
        drive("ertn_k0", 1, nop);
        drive("ertn_k1", 0, nop);
        check("ertn.instret", instret, 64'd5);

        drive("csrwr", 1, mk(0, 0, 14'h0006, 1, 32'hdead_beef, 0, 32'h1c00_0400, 1, 5'd12, 32'h5));
        drive("bub1", 0, nop);
        drive("nogr", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0500, 0, 5'd13, 32'h1234));
        drive("r0wr", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0504, 1, 5'd0, 32'h77));
        drive("exc_ertn", 1, mk(1, 6'h08, 0, 0, 0, 1, 32'h1c00_0600, 1, 5'd3, 32'h88));
        drive("ee_k0", 0, nop);
        drive("ee_k1", 0, nop);

        drive("exc2", 1, mk(1, 6'h0c, 0, 0, 0, 0, 32'h1c00_0700, 0, 5'd0, 32'h0));
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid");
        q.delete();
        m_valid = 1'b0; m_kill = 1'b0; m_excp = 1'b0; m_ertn = 1'b0;
        exp_instret = 64'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive("post_rst", 1, mk(0, 0, 0, 0, 0, 0, 32'h1c00_0800, 1, 5'd14, 32'hcafe));
        drive("bub2", 0, nop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
